// File: rtl/mul32_seq_pkg.sv
// mul32_seq_pkg: shared state encodings and default operand width for the ALU multiplier.
package mul32_seq_pkg;
  localparam int N = 32;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/mul32_seq_mul_step.sv
// mul_step: one shift-add iteration, conditional add of mcand then shift {acc, mplier} right.
module mul_step #(
  parameter int n = 32
) (
  input  logic [n:0]   acc,
  input  logic [n-1:0] mplier,
  input  logic [n-1:0] mcand,
  output logic [n:0]   acc_next,
  output logic [n-1:0] mplier_next
);
  logic [n:0] sum;
  assign sum = acc + {1'b0, mplier[0] ? mcand : {n{1'b0}}};
  assign acc_next = {1'b0, sum[n:1]};
  assign mplier_next = {sum[0], mplier[n-1:1]};
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: iterative signed/unsigned shift-add multiplier with start/busy/done handshake.
module mul32_seq
  import mul32_seq_pkg::*;
#(
  parameter int n = N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         Signed_Op,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [n-1:0] Mul_Hi,
  output logic [n-1:0] Mul_Lo,
  output logic         Mul_Zero,
  output logic         Mul_Overflow
);
  localparam int cw = $clog2(n + 1);
  logic [1:0] state;
  logic signed_op, neg;
  logic [n-1:0] mcand, mplier, mplier_next;
  logic [n:0] acc, acc_next;
  logic [cw-1:0] count;
  logic [2*n-1:0] raw, p;
  logic ovf;
  mul_step #(.n(n)) u_step (
    .acc(acc),
    .mplier(mplier),
    .mcand(mcand),
    .acc_next(acc_next),
    .mplier_next(mplier_next)
  );
  // acc's top bit is always zero after the final shift, so truncation is lossless
  assign raw = (2*n)'({acc, mplier});
  assign p = neg ? -raw : raw;
  assign ovf = signed_op ? (p[2*n-1:n] != {n{p[n-1]}}) : |p[2*n-1:n];
  assign Busy = (state == CALC) || (state == FIX);
  assign Done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      signed_op <= 1'b0;
      neg <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      count <= '0;
      Mul_Hi <= '0;
      Mul_Lo <= '0;
      Mul_Zero <= 1'b1;
      Mul_Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          signed_op <= Signed_Op;
          mcand <= (Signed_Op && A[n-1]) ? -A : A;
          mplier <= (Signed_Op && B[n-1]) ? -B : B;
          neg <= Signed_Op & (A[n-1] ^ B[n-1]);
          acc <= '0;
          count <= cw'(n);
          state <= CALC;
        end
        CALC: begin
          acc <= acc_next;
          mplier <= mplier_next;
          count <= count - 1'b1;
          if (count == cw'(1)) state <= FIX;
        end
        FIX: begin
          Mul_Hi <= p[2*n-1:n];
          Mul_Lo <= p[n-1:0];
          Mul_Zero <= ~|p;
          Mul_Overflow <= ovf;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: directed vectors with hand-computed products for mul32_seq.
module tb_mul32_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, Signed_Op = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic Busy, Done, Mul_Zero, Mul_Overflow;
  logic [31:0] Mul_Hi, Mul_Lo;
  int n_vec = 0, n_bad = 0;

  mul32_seq dut (
    .clk(clk), .rst(rst), .start(start), .Signed_Op(Signed_Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Mul_Hi(Mul_Hi), .Mul_Lo(Mul_Lo),
    .Mul_Zero(Mul_Zero), .Mul_Overflow(Mul_Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Signed_Op = s; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bsy);
    lat = 0; bsy = 0;
    while (!Done && lat < 100) begin
      if (Busy) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (Done) pulses++;
    end
  endtask

  task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] prod, input logic z, input logic o);
    int lat, bsy;
    start_op(s, a, b);
    wait_done(lat, bsy);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(bsy), 64'd33);
    chk({tag, "_prod"}, {Mul_Hi, Mul_Lo}, prod);
    chk({tag, "_zero"}, 64'(Mul_Zero), 64'(z));
    chk({tag, "_ovf"}, 64'(Mul_Overflow), 64'(o));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int lat, bsy, pulses;
    #12;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_prod", {Mul_Hi, Mul_Lo}, 64'd0);
    chk("rst_zero", 64'(Mul_Zero), 64'd1);
    chk("rst_ovf", 64'(Mul_Overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u3x5", 1'b0, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0);
    do_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    do_op("sm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
    do_op("sm2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);
    do_op("smin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b1);
    do_op("uzero", 1'b0, 32'd0, 32'h1234, 64'd0, 1'b1, 1'b0);
    do_op("slo_ovf", 1'b1, 32'h0001_0000, 32'h0000_8000, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
    do_op("uhi_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b1);

    // second start with new operands during CALC must be ignored
    start_op(1'b0, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    Signed_Op = 1'b1; A = 32'd100; B = 32'hFFFF_FFF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bsy);
    chk("ign_lat", 64'(lat), 64'd23);
    chk("ign_prod", {Mul_Hi, Mul_Lo}, 64'd63);
    count_done(40, pulses);
    chk("ign_pulses", 64'(pulses), 64'd0);
    chk("ign_idle", 64'(Busy), 64'd0);

    // asynchronous reset between edges mid-CALC
    start_op(1'b0, 32'h1234, 32'h5678);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(Busy), 64'd0);
    chk("arst_prod", {Mul_Hi, Mul_Lo}, 64'd0);
    chk("arst_zero", 64'(Mul_Zero), 64'd1);
    chk("arst_done", 64'(Done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, pulses);
    chk("arst_pulses", 64'(pulses), 64'd0);
    do_op("post_rst", 1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
